// File: rtl/dm_store_buffer.sv
// Store buffer in front of the data memory: queues stores, drains them when the DM port is idle,
// and stalls loads that hit a pending store. Optional load forwarding under `SB_FWD_EN.
module dm_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_sel,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_stall,
  output logic             ld_fwd_valid,
  output logic [31:0]      ld_fwd_data,
  input  logic             flush,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_di,
  output logic [1:0]       dm_sel,
  output logic             dm_en,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [1:0]       mem_sel  [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             is_empty;
  logic             push;
  logic             conflict;
`ifdef SB_FWD_EN
  logic             fwd_ok;
  logic [31:0]      fwd_word;
`endif

  assign full     = (cnt == CNT_W'(DEPTH));
  assign is_empty = (cnt == '0);
  assign st_ready = !full;
  assign empty    = is_empty;
  assign count    = cnt;
  assign push     = st_valid && !full;

  // Scan live entries oldest to youngest; the last match seen is the youngest.
  always_comb begin : match_scan
    logic [PTR_W-1:0] idx;
    idx      = '0;
    conflict = 1'b0;
`ifdef SB_FWD_EN
    fwd_ok   = 1'b0;
    fwd_word = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < cnt) && (mem_addr[idx][31:2] == ld_addr[31:2])) begin
        conflict = ld_valid;
`ifdef SB_FWD_EN
        fwd_ok   = ld_valid && (mem_sel[idx] == 2'b00) && (mem_addr[idx][1:0] == 2'b00);
        fwd_word = mem_data[idx];
`endif
      end
    end
  end

  assign dm_en = !is_empty && (!ld_valid || flush || conflict || full);

`ifdef SB_FWD_EN
  assign ld_fwd_valid = fwd_ok && !dm_en;
  assign ld_fwd_data  = ld_fwd_valid ? fwd_word : 32'h0;
  assign ld_stall     = ld_valid && (dm_en || (conflict && !fwd_ok));
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = 32'h0;
  assign ld_stall     = ld_valid && (dm_en || conflict);
`endif

  // DM port: head entry while draining, otherwise the load address; all zero in reset.
  always_comb begin : port_mux
    dm_addr = '0;
    dm_di   = '0;
    dm_sel  = '0;
    if (dm_en) begin
      dm_addr = mem_addr[head];
      dm_di   = mem_data[head];
      dm_sel  = mem_sel[head];
    end else if (reset) begin
      dm_addr = ld_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (dm_en) head <= head + PTR_W'(1);
      case ({push, dm_en})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payloads need no reset; occupancy is tracked by head/cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= st_addr;
      mem_data[tail] <= st_data;
      mem_sel[tail]  <= st_sel;
    end
  end

endmodule
